// File: rtl/ram_loader.sv
// Streams bytes into RAM port A from a valid/ready source, keeping a mod-2^DATA_W checksum,
// then reads the region back through the same port and flags any checksum mismatch.
module ram_loader #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum,
  output logic              verify_err
);

  typedef enum logic [2:0] {StIdle, StLoad, StVerify, StVwait, StDone} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [DATA_W-1:0]   csum_q, csum_d;
  logic [DATA_W-1:0]   rd_sum_q, rd_sum_d;
  logic                rd_vld_q, rd_vld_d;
  logic                err_q, err_d;
  logic                handshake;

  assign in_ready   = (state_q == StLoad);
  assign handshake  = in_valid & in_ready;
  assign ram_we     = handshake;
  assign ram_addr   = addr_q;
  assign ram_wdata  = in_data;
  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);
  assign checksum   = csum_q;
  assign verify_err = err_q;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    base_d   = base_q;
    count_d  = count_q;
    len_d    = len_q;
    csum_d   = csum_q;
    err_d    = err_q;
    rd_vld_d = 1'b0;
    // Read data arrives one cycle after its address was issued.
    rd_sum_d = rd_sum_q + (rd_vld_q ? ram_rdata : DATA_W'(0));

    unique case (state_q)
      StIdle: begin
        if (start) begin
          base_d   = base_addr;
          len_d    = length;
          addr_d   = base_addr;
          count_d  = length;
          csum_d   = '0;
          err_d    = 1'b0;
          rd_sum_d = '0;
          state_d  = (length == '0) ? StDone : StLoad;
        end
      end
      StLoad: begin
        if (handshake) begin
          csum_d = csum_q + in_data;
          if (count_q == (ADDR_W+1)'(1)) begin
            addr_d  = base_q;
            count_d = len_q;
            state_d = StVerify;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            count_d = count_q - (ADDR_W+1)'(1);
          end
        end
      end
      StVerify: begin
        rd_vld_d = 1'b1;
        addr_d   = addr_q + ADDR_W'(1);
        count_d  = count_q - (ADDR_W+1)'(1);
        if (count_q == (ADDR_W+1)'(1)) state_d = StVwait;
      end
      StVwait: begin
        // Compare against the sum including the final byte landing this cycle.
        err_d   = (rd_sum_d != csum_q);
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      base_q   <= '0;
      count_q  <= '0;
      len_q    <= '0;
      csum_q   <= '0;
      rd_sum_q <= '0;
      rd_vld_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      base_q   <= base_d;
      count_q  <= count_d;
      len_q    <= len_d;
      csum_q   <= csum_d;
      rd_sum_q <= rd_sum_d;
      rd_vld_q <= rd_vld_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
// Self-checking bench for ram_loader with a behavioural 16K x 8 dual-port RAM attached to port A.
module tb_ram_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [13:0] base_addr;
  logic [14:0] length;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [13:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic [7:0]  ram_rdata;
  logic        busy;
  logic        done;
  logic [7:0]  checksum;
  logic        verify_err;

  logic [7:0]  mem [16384];
  logic [13:0] b_addr;
  logic [7:0]  b_wdata;
  logic        b_we;
  logic [7:0]  q_b;

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  logic [13:0] wr_log [64];

  always #5 clk = ~clk;

  ram_loader #(.ADDR_W(14), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata), .busy(busy), .done(done),
    .checksum(checksum), .verify_err(verify_err)
  );

  // Dual-port RAM model: port A from the loader, port B from the bench.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    if (b_we) mem[b_addr] <= b_wdata;
    ram_rdata <= mem[ram_addr];
    q_b <= mem[b_addr];
  end

  always @(posedge clk) begin
    if (ram_we) begin
      wr_log[wr_cnt % 64] <= ram_addr;
      wr_cnt <= wr_cnt + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic b_write(input logic [13:0] a, input logic [7:0] d);
    @(negedge clk);
    b_we = 1'b1; b_addr = a; b_wdata = d;
    @(negedge clk);
    b_we = 1'b0;
  endtask

  task automatic b_read(input logic [13:0] a, output logic [7:0] d);
    @(negedge clk);
    b_addr = a;
    @(negedge clk);
    d = q_b;
  endtask

  task automatic pulse_start(input logic [13:0] b, input logic [14:0] l);
    @(negedge clk);
    start = 1'b1; base_addr = b; length = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for done at negedges; returns cycles waited (bound expiry -> 999).
  task automatic wait_done(output int k);
    k = 0;
    while (!done && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (!done) k = 999;
  endtask

  typedef struct {
    logic [13:0]     base;
    logic [14:0]     len;
    logic [3:0][7:0] d;
    int              gap_after;
    int              gap_len;
    logic [13:0]     first_a;
    logic [13:0]     last_a;
    logic [7:0]      csum;
  } vec_t;

  function automatic vec_t mk(input logic [13:0] base, input logic [14:0] len,
                              input logic [31:0] d, input int ga, input int gl,
                              input logic [13:0] fa, input logic [13:0] la,
                              input logic [7:0] cs);
    vec_t v;
    v.base = base; v.len = len; v.d = d; v.gap_after = ga; v.gap_len = gl;
    v.first_a = fa; v.last_a = la; v.csum = cs;
    return v;
  endfunction

  vec_t vec [3];

  initial begin
    int k, wr0, dn0;
    logic [7:0] q;
    logic [13:0] a;

    vec[0] = mk(14'h0010, 15'd4, 32'h04030201, -1, 0, 14'h0010, 14'h0013, 8'h0A);
    vec[1] = mk(14'h0010, 15'd4, 32'h04030201,  2, 3, 14'h0010, 14'h0013, 8'h0A);
    vec[2] = mk(14'h3FFE, 15'd3, 32'h00CCBBAA, -1, 0, 14'h3FFE, 14'h0000, 8'h31);

    rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0;
    in_data = '0; in_valid = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_done", done, 0);
    chk("rst_verify_err", verify_err, 0);
    chk("rst_checksum", checksum, 0);
    chk("rst_ram_addr", ram_addr, 0);
    rst_n = 1'b1;

    // in_valid while idle consumes nothing
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h55;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    chk("idle_no_write", wr_cnt, 0);
    chk("idle_in_ready", in_ready, 0);

    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < int'(vec[i].len); j++) begin
        a = vec[i].base + 14'(j);
        b_write(a, 8'hEE);
      end
      wr0 = wr_cnt; dn0 = done_cnt;
      pulse_start(vec[i].base, vec[i].len);
      chk("load_in_ready", in_ready, 1);
      chk("load_busy", busy, 1);
      for (int j = 0; j < int'(vec[i].len); j++) begin
        if (j == vec[i].gap_after) begin
          in_valid = 1'b0;
          for (int g = 0; g < vec[i].gap_len; g++) begin
            @(negedge clk);
            chk("gap_no_we", ram_we, 0);
          end
        end
        in_valid = 1'b1; in_data = vec[i].d[j];
        @(negedge clk);
      end
      in_valid = 1'b0;
      wait_done(k);
      chk("done_latency", k, vec[i].len + 1);
      chk("checksum", checksum, vec[i].csum);
      chk("verify_err", verify_err, 0);
      chk("write_count", wr_cnt - wr0, vec[i].len);
      chk("first_addr", wr_log[wr0 % 64], vec[i].first_a);
      chk("last_addr", wr_log[(wr0 + int'(vec[i].len) - 1) % 64], vec[i].last_a);
      @(negedge clk);
      chk("done_once", done_cnt - dn0, 1);
      chk("idle_after_done", busy, 0);
      for (int j = 0; j < int'(vec[i].len); j++) begin
        a = vec[i].base + 14'(j);
        b_read(a, q);
        chk("ram_content", q, vec[i].d[j]);
      end
    end

    // Corruption during verify: zero base+1 via port B before its readback
    pulse_start(14'h0020, 15'd4);
    for (int j = 0; j < 4; j++) begin
      in_valid = 1'b1; in_data = 8'(5 + j);
      @(negedge clk);
    end
    in_valid = 1'b0;
    b_we = 1'b1; b_addr = 14'h0021; b_wdata = 8'h00;
    @(negedge clk);
    b_we = 1'b0;
    wait_done(k);
    chk("corrupt_done_seen", (k < 60) ? 1 : 0, 1);
    chk("corrupt_checksum", checksum, 8'h1A);
    chk("corrupt_err", verify_err, 1);
    repeat (5) @(negedge clk);
    chk("corrupt_err_hold", verify_err, 1);

    // length = 0: done on the next cycle, no writes, results cleared
    wr0 = wr_cnt;
    pulse_start(14'h0100, 15'd0);
    chk("len0_done", done, 1);
    chk("len0_busy", busy, 1);
    chk("len0_checksum", checksum, 0);
    chk("len0_err", verify_err, 0);
    @(negedge clk);
    chk("len0_no_write", wr_cnt - wr0, 0);
    chk("len0_idle", busy, 0);

    // start during LOAD is ignored
    wr0 = wr_cnt; dn0 = done_cnt;
    pulse_start(14'h0200, 15'd2);
    in_valid = 1'b1; in_data = 8'h10;
    @(negedge clk);
    in_valid = 1'b0; start = 1'b1; base_addr = 14'h0300; length = 15'd5;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1; in_data = 8'h20;
    @(negedge clk);
    in_valid = 1'b0;
    wait_done(k);
    chk("ign_latency", k, 3);
    chk("ign_checksum", checksum, 8'h30);
    chk("ign_writes", wr_cnt - wr0, 2);
    chk("ign_addr", wr_log[(wr0 + 1) % 64], 14'h0201);

    // Reset mid-load after 2 of 4 bytes
    repeat (2) @(negedge clk);
    dn0 = done_cnt;
    pulse_start(14'h0040, 15'd4);
    in_valid = 1'b1; in_data = 8'h11;
    @(negedge clk);
    in_data = 8'h22;
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    chk("rstm_busy", busy, 0);
    chk("rstm_in_ready", in_ready, 0);
    chk("rstm_checksum", checksum, 0);
    chk("rstm_done", done, 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("rstm_no_done", done_cnt - dn0, 0);
    b_read(14'h0040, q);
    chk("rstm_mem0", q, 8'h11);
    b_read(14'h0041, q);
    chk("rstm_mem1", q, 8'h22);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
